eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
- Shares one byte-wide AXI-Stream Ethernet transmit path (feeding the MII transmit serializer) between NUM_PORTS frame sources.
- Arbitrates round-robin at frame granularity.
- Enforces a minimum idle gap between frames.
- Truncates and marks oversized frames so a runaway source cannot hold the transmitter.

Parameters:
- NUM_PORTS, 2: number of requesting AXIS sources (2..8).
- IFG_CYCLES, 24: idle clocks inserted after each frame ends (24 = 12 byte-times at 2 clocks/byte). 0 disables the gap.
- MAX_FRAME_BYTES, 1518: maximum bytes forwarded per frame (2..65535).

Ports:
- clock  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low, on clock.
- s_tdata  in  8*NUM_PORTS  source bytes; port i in bits [8i+7:8i].
- s_tvalid  in  NUM_PORTS  per-source valid.
- s_tready  out  NUM_PORTS  per-source ready.
- s_tlast  in  NUM_PORTS  per-source end of frame.
- s_tuser  in  NUM_PORTS  per-source error flag (propagated).
- m_tdata  out  8  granted byte to transmitter.
- m_tvalid  out  1  output valid.
- m_tready  in  1  transmitter ready.
- m_tlast  out  1  end of frame.
- m_tuser  out  1  frame error/abort.
- grant  out  max(1,$clog2(NUM_PORTS))  index of the current/last granted port.
- busy  out  1  high in any state except IDLE.
- frames_sent  out  16  completed frames, truncated ones included; wraps at 65535->0.
- frames_truncated  out  16  frames cut at MAX_FRAME_BYTES; wraps.

Behaviour:
- Reset state: state=IDLE, grant=NUM_PORTS-1 (port 0 wins first), byte counter and gap counter 0, both status counters 0. While in reset and in IDLE: s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0.
- Reset asserted mid-frame: immediate return to IDLE next edge. The partial frame is not terminated on m_*. Status counters clear.
- State IDLE:
  - If any s_tvalid is high, pick the first set bit scanning grant+1, grant+2, ... modulo NUM_PORTS. Register the pick into grant, clear the byte counter, go to FWD.
  - One cycle of arbitration latency: no byte moves in IDLE.
  - If no s_tvalid is high, stay in IDLE.
- State FWD (combinational pass-through from port g=grant):
  - m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], s_tready[g]=m_tready. All other s_tready=0.
  - Handshake = m_tvalid && m_tready. The byte counter increments on each handshake.
  - Normal output: m_tlast=s_tlast[g], m_tuser=s_tuser[g].
  - Handshake with s_tlast[g]=1: frames_sent++, go to GAP.
  - Cut point: byte counter == MAX_FRAME_BYTES-1 and s_tlast[g]=0.
    - Force m_tlast=1 and m_tuser=1 on that beat.
    - On handshake at the cut point: frames_sent++, frames_truncated++, go to DRAIN.
  - If the source's own tlast lands exactly on byte MAX_FRAME_BYTES, the frame is normal, not truncated.
  - A source deasserting tvalid mid-frame just stalls; the grant is held.
- State DRAIN:
  - s_tready[g]=1, m_tvalid=0. Remaining source bytes are discarded.
  - s_tvalid[g] && s_tlast[g]: go to GAP.
- State GAP:
  - All s_tready=0, m_tvalid=0.
  - Gap counter runs from IFG_CYCLES-1 down to 0, then IDLE. Exactly IFG_CYCLES cycles are spent in GAP.
  - IFG_CYCLES=0: FWD/DRAIN go directly to IDLE.
- Ordering and latency:
  - Minimum spacing from the last-byte handshake of one frame to the first possible byte of the next frame = IFG_CYCLES+2 clocks (GAP, IDLE, then FWD).
  - Simultaneous requests resolve strictly round-robin. A port that just transmitted is lowest priority next time.
- busy=1 in FWD, DRAIN and GAP.

Test Plan:
- Single frame, port 0, 60 bytes 0x00..0x3B, m_tready=1, IFG_CYCLES=24:
  - m_* carries the identical 60 bytes with tlast on 0x3B and m_tuser=0.
  - frames_sent=1.
  - busy stays high 24 cycles after the last beat.
- Ports 0 and 1 both hold 3 back-to-back frames each from reset:
  - Output order is P0,P1,P0,P1,P0,P1.
  - Each frame start is ≥26 clocks after the prior tlast handshake.
- Backpressure: m_tready toggles 1,0,1,0 with port 1 sending 10 bytes:
  - s_tready[1] mirrors m_tready; no byte is lost or duplicated.
  - s_tready[0]=0 throughout.
- MAX_FRAME_BYTES=64, port 0 sends 100 bytes:
  - Exactly 64 bytes out, byte 64 has m_tlast=1 and m_tuser=1.
  - Bytes 65..100 are accepted with m_tvalid=0.
  - frames_truncated=1, frames_sent=1.
- MAX_FRAME_BYTES=64, exactly 64-byte frame with s_tlast on byte 64: m_tuser=0, frames_truncated=0.
- Reset asserted after 20 bytes of a frame:
  - The next cycle has m_tvalid=0, s_tready=0, counters 0, grant=NUM_PORTS-1.
  - After release, port 0 is granted first.

Source files
------------

// File: rtl/eth_tx_frame_arbiter_if.sv
// Byte-wide AXI-Stream bundle between NUM_PORTS frame sources, the arbiter and the MII transmitter.
// The master modport is the arbiter side: it drives the shared transmit bus and the per-source readies.
interface eth_tx_frame_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [8*NUM_PORTS-1:0] s_tdata;
  logic [NUM_PORTS-1:0]   s_tvalid;
  logic [NUM_PORTS-1:0]   s_tready;
  logic [NUM_PORTS-1:0]   s_tlast;
  logic [NUM_PORTS-1:0]   s_tuser;
  logic [7:0]             m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   m_tuser;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for a shared byte-wide Ethernet transmit path,
// with an enforced inter-frame gap and truncation of frames longer than MAX_FRAME_BYTES.
module eth_tx_frame_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int IFG_CYCLES      = 24,
  parameter int MAX_FRAME_BYTES = 1518,
  localparam int GW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clock,
  input  logic                    aresetn,
  eth_tx_frame_arbiter_if.master  bus,
  output logic [GW-1:0]           grant,
  output logic                    busy,
  output logic [15:0]             frames_sent,
  output logic [15:0]             frames_truncated
);

  localparam int          CW      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [15:0] CUT_IDX = 16'(MAX_FRAME_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DRAIN, S_GAP} state_t;

  state_t         r_state;
  logic [GW-1:0]  r_grant;
  logic [15:0]    r_byte_cnt;
  logic [CW-1:0]  r_gap_cnt;
  logic [15:0]    r_sent;
  logic [15:0]    r_trunc;

  logic [7:0]           w_src_data [NUM_PORTS];
  logic [GW-1:0]        w_pick;
  logic                 w_found;
  logic                 w_valid_g;
  logic                 w_last_g;
  logic                 w_user_g;
  logic                 w_cut;
  logic                 w_hs;
  logic [NUM_PORTS-1:0] w_s_tready;
  logic [7:0]           w_m_tdata;
  logic                 w_m_tvalid;
  logic                 w_m_tlast;
  logic                 w_m_tuser;

  // Unpack the flat source data bus into per-port bytes.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_src_data[i] = bus.s_tdata[8*i +: 8];
    end
  end

  // Round-robin scan starting just after the last grant; the lowest offset with a request wins.
  always_comb begin
    w_pick  = r_grant;
    w_found = 1'b0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (bus.s_tvalid[GW'((int'(r_grant) + i) % NUM_PORTS)]) begin
        w_pick  = GW'((int'(r_grant) + i) % NUM_PORTS);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_valid_g = bus.s_tvalid[r_grant];
  assign w_last_g  = bus.s_tlast[r_grant];
  assign w_user_g  = bus.s_tuser[r_grant];
  assign w_cut     = (r_state == S_FWD) && (r_byte_cnt == CUT_IDX) && !w_last_g;
  assign w_hs      = w_m_tvalid && bus.m_tready;

  // Bus steering: pass-through in FWD, sink-only in DRAIN, everything quiet in reset.
  always_comb begin
    w_s_tready = '0;
    w_m_tdata  = 8'h00;
    w_m_tvalid = 1'b0;
    w_m_tlast  = 1'b0;
    w_m_tuser  = 1'b0;
    if (aresetn) begin
      case (r_state)
        S_FWD: begin
          w_m_tdata           = w_src_data[r_grant];
          w_m_tvalid          = w_valid_g;
          w_s_tready[r_grant] = bus.m_tready;
          w_m_tlast           = w_cut ? 1'b1 : w_last_g;
          w_m_tuser           = w_cut ? 1'b1 : w_user_g;
        end
        S_DRAIN: w_s_tready[r_grant] = 1'b1;
        default: w_s_tready = '0;
      endcase
    end else begin
      w_s_tready = '0;
    end
  end

  // Arbiter FSM plus byte, gap and status counters.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_grant    <= GW'(NUM_PORTS - 1);
      r_byte_cnt <= 16'd0;
      r_gap_cnt  <= '0;
      r_sent     <= 16'd0;
      r_trunc    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_byte_cnt <= 16'd0;
            r_state    <= S_FWD;
          end
        end
        S_FWD: begin
          if (w_hs) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            if (w_cut) begin
              r_sent  <= r_sent + 16'd1;
              r_trunc <= r_trunc + 16'd1;
              r_state <= S_DRAIN;
            end else if (w_last_g) begin
              r_sent <= r_sent + 16'd1;
              if (IFG_CYCLES == 0) begin
                r_state <= S_IDLE;
              end else begin
                r_gap_cnt <= CW'(IFG_CYCLES - 1);
                r_state   <= S_GAP;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_valid_g && w_last_g) begin
            if (IFG_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= CW'(IFG_CYCLES - 1);
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_tready     = w_s_tready;
  assign bus.m_tdata      = w_m_tdata;
  assign bus.m_tvalid     = w_m_tvalid;
  assign bus.m_tlast      = w_m_tlast;
  assign bus.m_tuser      = w_m_tuser;
  assign grant            = r_grant;
  assign busy             = (r_state != S_IDLE);
  assign frames_sent      = r_sent;
  assign frames_truncated = r_trunc;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench: frames are queued per port, a frame-level model predicts every output beat,
// gap and idle cycle, and counters; literal checks pin the model on the headline scenarios.
module tb_eth_tx_frame_arbiter;
  localparam int NP   = 2;
  localparam int IFG  = 24;
  localparam int MAXB = 64;

  logic        clock = 1'b0;
  logic        aresetn = 1'b0;
  logic [0:0]  grant;
  logic        busy;
  logic [15:0] frames_sent;
  logic [15:0] frames_truncated;

  always #5 clock = ~clock;

  eth_tx_frame_arbiter_if #(.NUM_PORTS(NP)) bus ();

  eth_tx_frame_arbiter #(
    .NUM_PORTS(NP), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clock(clock), .aresetn(aresetn), .bus(bus.master), .grant(grant),
    .busy(busy), .frames_sent(frames_sent), .frames_truncated(frames_truncated)
  );

  typedef struct packed {logic [7:0] d; logic l;} src_beat_t;
  typedef struct packed {logic [7:0] d; logic l; logic u; logic [3:0] port; logic first; logic trunc;} exp_beat_t;

  src_beat_t  src_q [NP][$];
  exp_beat_t  exp_q [$];
  logic [7:0] out_q [$];
  int         order_q [$];

  int checks = 0, failures = 0;
  int m_sent, m_trunc, gap_left, gap_busy, ncyc = 0, last_end, drained, hs_count, drain_port, min_space;
  bit post_idle, draining, toggle_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sent = 0; m_trunc = 0; gap_left = 0; gap_busy = 0; last_end = -1000;
    drained = 0; post_idle = 0; draining = 0; drain_port = 0;
  endtask

  // A source frame of len bytes base, base+1, ...; the transmitter sees at most MAXB of them.
  task automatic add_frame(input int p, input int len, input int base);
    int n;
    n = (len > MAXB) ? MAXB : len;
    for (int i = 0; i < len; i++) src_q[p].push_back('{d: 8'(base + i), l: (i == len - 1)});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: 8'(base + i), l: (i == n - 1), u: (len > MAXB) && (i == n - 1),
                        port: 4'(p), first: (i == 0), trunc: (len > MAXB) && (i == n - 1)});
  endtask

  task automatic start_gap();
    gap_left = IFG; gap_busy = 0; last_end = ncyc;
  endtask

  // Per-cycle compare of the DUT against the frame-level model (called at the negedge).
  task automatic model_step();
    exp_beat_t e;
    chk("frames_sent", 32'(frames_sent), 32'(m_sent));
    chk("frames_truncated", 32'(frames_truncated), 32'(m_trunc));
    if (gap_left > 0) begin
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("gap_sready", 32'(bus.s_tready), 32'd0);
      if (busy) gap_busy++;
      gap_left--;
      if (gap_left == 0) post_idle = 1'b1;
    end else if (post_idle) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("idle_sready", 32'(bus.s_tready), 32'd0);
      post_idle = 1'b0;
    end else if (draining) begin
      chk("drain_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("drain_sready", 32'(bus.s_tready), 32'd1 << drain_port);
      if (bus.s_tvalid[drain_port]) drained++;
      if (bus.s_tvalid[drain_port] && bus.s_tlast[drain_port]) begin
        draining = 1'b0;
        start_gap();
      end
    end else if (bus.m_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(bus.m_tvalid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("fwd_sready", 32'(bus.s_tready), bus.m_tready ? (32'd1 << e.port) : 32'd0);
        if (bus.m_tready) begin
          void'(exp_q.pop_front());
          hs_count++;
          out_q.push_back(bus.m_tdata);
          chk("m_tdata", 32'(bus.m_tdata), 32'(e.d));
          chk("m_tlast", 32'(bus.m_tlast), 32'(e.l));
          chk("m_tuser", 32'(bus.m_tuser), 32'(e.u));
          if (e.first) begin
            chk("grant", 32'(grant), 32'(e.port));
            chk("ifg_spacing", 32'(ncyc - last_end >= IFG + 2), 32'd1);
            if (last_end >= 0 && ncyc - last_end < min_space) min_space = ncyc - last_end;
            order_q.push_back(int'(e.port));
          end
          if (e.l) begin
            m_sent++;
            if (e.trunc) begin
              m_trunc++;
              draining = 1'b1;
              drain_port = int'(e.port);
            end else begin
              start_gap();
            end
          end
        end
      end
    end else if (!busy) begin
      chk("idle_sready", 32'(bus.s_tready), 32'd0);
    end
    ncyc++;
  endtask

  // Drive queued source beats cycle by cycle until the model is drained (or stop_beats beats moved).
  task automatic run(input int budget, input int stop_beats);
    int cyc = 0;
    bit done = 1'b0;
    bit hs [NP];
    logic [NP-1:0] v, l;
    logic [8*NP-1:0] d;
    hs_count = 0;
    while (!done && cyc < budget) begin
      v = '0; l = '0; d = '0;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          v[p] = 1'b1;
          l[p] = src_q[p][0].l;
          d[8*p +: 8] = src_q[p][0].d;
        end
      end
      bus.s_tvalid = v; bus.s_tlast = l; bus.s_tdata = d; bus.s_tuser = '0;
      bus.m_tready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      @(negedge clock);
      for (int p = 0; p < NP; p++) hs[p] = bus.s_tvalid[p] && bus.s_tready[p];
      model_step();
      @(posedge clock); #1;
      for (int p = 0; p < NP; p++) if (hs[p]) void'(src_q[p].pop_front());
      cyc++;
      if (stop_beats > 0) done = (hs_count >= stop_beats);
      else done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (exp_q.size() == 0) &&
                  (gap_left == 0) && !post_idle && !draining;
    end
    chk("run_timeout", 32'(done), 32'd1);
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.m_tready = 1'b1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.s_tuser = '0; bus.m_tready = 1'b1;
    src_q[0].delete(); src_q[1].delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_mtdata", 32'(bus.m_tdata), 32'd0);
    chk("rst_mtlast", 32'(bus.m_tlast), 32'd0);
    chk("rst_mtuser", 32'(bus.m_tuser), 32'd0);
    chk("rst_sready", 32'(bus.s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_frames_sent", 32'(frames_sent), 32'd0);
    chk("rst_frames_trunc", 32'(frames_truncated), 32'd0);
    @(posedge clock); #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  initial begin
    toggle_ready = 1'b0;
    do_reset();

    // Single 60-byte frame from port 0.
    out_q.delete();
    add_frame(0, 60, 0);
    run(2000, 0);
    chk("t1_bytes", 32'(out_q.size()), 32'd60);
    chk("t1_first_byte", 32'(out_q[0]), 32'h00);
    chk("t1_last_byte", 32'(out_q[59]), 32'h3B);
    chk("t1_frames_sent", 32'(frames_sent), 32'd1);
    chk("t1_gap_busy", 32'(gap_busy), 32'd24);

    // Both ports with three back-to-back frames from reset: strict alternation, 26-clock spacing.
    do_reset();
    order_q.delete();
    min_space = 1000000;
    for (int f = 0; f < 3; f++) begin
      add_frame(0, 5, 8'h10 + 16 * f);
      add_frame(1, 5, 8'h80 + 16 * f);
    end
    run(3000, 0);
    chk("t2_frames", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t2_order", 32'(order_q[i]), 32'(i % 2));
    chk("t2_min_spacing", 32'(min_space), 32'd26);
    chk("t2_frames_sent", 32'(frames_sent), 32'd6);

    // Port 1, 10 bytes, transmitter ready alternating.
    out_q.delete();
    toggle_ready = 1'b1;
    add_frame(1, 10, 8'hA0);
    run(2000, 0);
    toggle_ready = 1'b0;
    chk("t3_bytes", 32'(out_q.size()), 32'd10);
    chk("t3_byte9", 32'(out_q[9]), 32'hA9);
    chk("t3_frames_sent", 32'(frames_sent), 32'd7);

    // 100-byte frame cut at 64, remaining 36 bytes drained.
    out_q.delete();
    add_frame(0, 100, 0);
    run(2000, 0);
    chk("t4_bytes", 32'(out_q.size()), 32'd64);
    chk("t4_drained", 32'(drained), 32'd36);
    chk("t4_frames_trunc", 32'(frames_truncated), 32'd1);
    chk("t4_frames_sent", 32'(frames_sent), 32'd8);

    // Exactly 64 bytes with tlast on byte 64: a normal frame.
    out_q.delete();
    add_frame(0, 64, 8'h40);
    run(2000, 0);
    chk("t5_bytes", 32'(out_q.size()), 32'd64);
    chk("t5_frames_trunc", 32'(frames_truncated), 32'd1);
    chk("t5_frames_sent", 32'(frames_sent), 32'd9);

    // Reset after 20 bytes of a frame, then port 0 must win first again.
    add_frame(0, 40, 0);
    run(2000, 20);
    aresetn = 1'b0;
    src_q[0].delete(); src_q[1].delete();
    bus.s_tvalid = '0; bus.s_tlast = '0;
    @(negedge clock);
    chk("t6_mvalid", 32'(bus.m_tvalid), 32'd0);
    chk("t6_sready", 32'(bus.s_tready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t6_frames_sent", 32'(frames_sent), 32'd0);
    chk("t6_frames_trunc", 32'(frames_truncated), 32'd0);
    chk("t6_grant", 32'(grant), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    aresetn = 1'b1;
    model_reset();
    order_q.delete();
    add_frame(0, 2, 8'hB0);
    add_frame(1, 2, 8'hC0);
    run(2000, 0);
    chk("t6_first_port", 32'(order_q[0]), 32'd0);
    chk("t6_frames_sent_after", 32'(frames_sent), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
